// File: rtl/nukv_privacy_pkg.sv
// Shared constants, FSM encodings and helpers for the nukv privacy datapath.
package nukv_privacy_pkg;

   localparam int DATA_W = 512;

   typedef enum logic {
      ARB_STATE_IDLE = 1'b0,
      ARB_STATE_XFER = 1'b1
   } arb_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/nukv_tag_fifo.sv
// Tag FIFO recording grant order; push and pop may occur in the same cycle.
module nukv_tag_fifo
   import nukv_privacy_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nukv_rotation_arbiter.sv
// Packet round-robin front end for the shared rotation engine, tag-steered responses.
// Optional per-requester job counters when ROT_ARB_STATS_EN is defined.
module nukv_rotation_arbiter
   import nukv_privacy_pkg::*;
#(
   parameter int NUM_REQ            = 4,
   parameter int TAG_DEPTH          = 4,
   parameter int RESP_LASTS_PER_JOB = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         eng_in_data,
   output logic                      eng_in_valid,
   output logic                      eng_in_last,
   input  logic                      eng_in_ready,
   input  logic [DATA_W-1:0]         eng_out_data,
   input  logic                      eng_out_valid,
   input  logic                      eng_out_last,
   output logic                      eng_out_ready,
   output logic [DATA_W-1:0]         resp_data,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic                      resp_last,
   input  logic [NUM_REQ-1:0]        resp_ready
`ifdef ROT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]     stat_jobs
`endif
);

   localparam int IDW = clog2(NUM_REQ);
   localparam int LCW = (clog2(RESP_LASTS_PER_JOB) < 1) ?
                        1 : clog2(RESP_LASTS_PER_JOB);
   localparam logic [LCW-1:0] LC_MAX = LCW'(RESP_LASTS_PER_JOB - 1);

   arb_state_t     state;
   arb_state_t     state_nxt;
   logic [IDW-1:0] grant_id;
   logic [IDW-1:0] grant_nxt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] rr_nxt;
   logic [IDW-1:0] pick;
   logic [IDW:0]   idx;
   logic           any_valid;
   logic           push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [IDW-1:0] head;
   logic [LCW-1:0] last_cnt;
   logic           resp_fire;

   // First valid requester at or after rr_ptr, walking cyclically.
   always_comb begin
      pick      = rr_ptr;
      any_valid = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (idx >= (IDW+1)'(NUM_REQ)) begin
            idx = idx - (IDW+1)'(NUM_REQ);
         end
         if (!any_valid && req_valid[idx[IDW-1:0]]) begin
            any_valid = 1'b1;
            pick      = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant_id;
      rr_nxt       = rr_ptr;
      push         = 1'b0;
      req_ready    = '0;
      eng_in_valid = 1'b0;
      eng_in_last  = 1'b0;
      eng_in_data  = req_data[grant_id*DATA_W +: DATA_W];
      unique case (state)
         ARB_STATE_IDLE: begin
            if (any_valid && !fifo_full) begin
               push      = 1'b1;
               grant_nxt = pick;
               state_nxt = ARB_STATE_XFER;
            end
         end
         ARB_STATE_XFER: begin
            eng_in_valid        = req_valid[grant_id];
            eng_in_last         = req_last[grant_id];
            req_ready[grant_id] = eng_in_ready;
            if (eng_in_valid && eng_in_ready && eng_in_last) begin
               rr_nxt    = (grant_id == IDW'(NUM_REQ - 1)) ?
                           '0 : grant_id + 1'b1;
               state_nxt = ARB_STATE_IDLE;
            end
         end
         default: state_nxt = ARB_STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ARB_STATE_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         rr_ptr   <= rr_nxt;
      end
   end

   nukv_tag_fifo #(
      .WIDTH (IDW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (pick),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Engine output follows the oldest outstanding tag.
   always_comb begin
      resp_valid    = '0;
      eng_out_ready = 1'b0;
      if (!fifo_empty) begin
         resp_valid[head] = eng_out_valid;
         eng_out_ready    = resp_ready[head];
      end
   end

   assign resp_data = eng_out_data;
   assign resp_last = eng_out_last;
   assign resp_fire = eng_out_valid && eng_out_ready && eng_out_last;
   assign pop       = resp_fire && (last_cnt == LC_MAX);

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_cnt <= '0;
      end else if (resp_fire) begin
         last_cnt <= pop ? '0 : last_cnt + 1'b1;
      end
   end

`ifdef ROT_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_jobs <= '0;
      end else if (pop) begin
         stat_jobs[head*16 +: 16] <= stat_jobs[head*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nukv_rotation_arbiter.sv
// Directed bench: cycle vector table plus hand sequences for stall, reset and backpressure.
module tb_nukv_rotation_arbiter;

   localparam int N  = 4;
   localparam int DW = 512;

   logic              clk;
   logic              rst;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic [DW-1:0]     eng_in_data;
   logic              eng_in_valid;
   logic              eng_in_last;
   logic              eng_in_ready;
   logic [DW-1:0]     eng_out_data;
   logic              eng_out_valid;
   logic              eng_out_last;
   logic              eng_out_ready;
   logic [DW-1:0]     resp_data;
   logic [N-1:0]      resp_valid;
   logic              resp_last;
   logic [N-1:0]      resp_ready;
`ifdef ROT_ARB_STATS_EN
   logic [N*16-1:0]   stat_jobs;
`endif

   nukv_rotation_arbiter #(
      .NUM_REQ            (N),
      .TAG_DEPTH          (4),
      .RESP_LASTS_PER_JOB (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .eng_in_data   (eng_in_data),
      .eng_in_valid  (eng_in_valid),
      .eng_in_last   (eng_in_last),
      .eng_in_ready  (eng_in_ready),
      .eng_out_data  (eng_out_data),
      .eng_out_valid (eng_out_valid),
      .eng_out_last  (eng_out_last),
      .eng_out_ready (eng_out_ready),
      .resp_data     (resp_data),
      .resp_valid    (resp_valid),
      .resp_last     (resp_last),
      .resp_ready    (resp_ready)
`ifdef ROT_ARB_STATS_EN
      ,
      .stat_jobs     (stat_jobs)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rst_first;
      logic [3:0] rv;
      logic [3:0] rl;
      logic       eir;
      logic       eov;
      logic       eol;
      logic [3:0] rr;
      logic [3:0] x_rr;
      logic       x_eiv;
      logic       x_eor;
      logic [3:0] x_rv;
      int         src;
   } vec_t;

   vec_t vecs[19];
   int   checks;
   int   failures;
   int   grants[$];
   int   resps[$];
   int   k;
   int   exp_owner;
   logic tog;
   logic [3:0] oh;

   function automatic vec_t mk(bit r, logic [3:0] rv, logic [3:0] rl,
                               logic eir, logic eov, logic eol,
                               logic [3:0] rr, logic [3:0] xrr,
                               logic xeiv, logic xeor,
                               logic [3:0] xrv, int src);
      vec_t v;
      v.rst_first = r;
      v.rv = rv; v.rl = rl; v.eir = eir; v.eov = eov; v.eol = eol;
      v.rr = rr; v.x_rr = xrr; v.x_eiv = xeiv; v.x_eor = xeor;
      v.x_rv = xrv; v.src = src;
      return v;
   endfunction

   function automatic logic [DW-1:0] pat(int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(i);
      return {16{w}};
   endfunction

   function automatic int owner(logic [3:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [DW-1:0] act,
                           input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h",
                  name, act[63:0], exp[63:0]);
      end
   endtask

   task automatic drive(input logic [3:0] rv, input logic [3:0] rl,
                        input logic eir, input logic eov,
                        input logic eol, input logic [3:0] rr);
      req_valid     = rv;
      req_last      = rl;
      eng_in_ready  = eir;
      eng_out_valid = eov;
      eng_out_last  = eol;
      resp_ready    = rr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      eng_out_data = '0;
      drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < N; i++) begin
         req_data[i*DW +: DW] = pat(i);
      end

      // single requester, 2-beat packet, three returned packets
      vecs[0]  = mk(1, 4'h1, 4'h0, 1, 0, 0, 4'hF, 4'h0, 0, 0, 4'h0, -1);
      vecs[1]  = mk(0, 4'h1, 4'h0, 1, 0, 0, 4'hF, 4'h1, 1, 1, 4'h0, 0);
      vecs[2]  = mk(0, 4'h1, 4'h1, 1, 0, 0, 4'hF, 4'h1, 1, 1, 4'h0, 0);
      vecs[3]  = mk(0, 4'h0, 4'h0, 1, 1, 0, 4'hF, 4'h0, 0, 1, 4'h1, -1);
      vecs[4]  = mk(0, 4'h0, 4'h0, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h1, -1);
      vecs[5]  = mk(0, 4'h0, 4'h0, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h1, -1);
      vecs[6]  = mk(0, 4'h0, 4'h0, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h1, -1);
      vecs[7]  = mk(0, 4'h0, 4'h0, 1, 1, 0, 4'hF, 4'h0, 0, 0, 4'h0, -1);
      // all requesters, single-beat packets, engine drains every cycle
      vecs[8]  = mk(1, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h0, 0, 0, 4'h0, -1);
      vecs[9]  = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h1, 1, 1, 4'h1, 0);
      vecs[10] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h1, -1);
      vecs[11] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h2, 1, 1, 4'h1, 1);
      vecs[12] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h2, -1);
      vecs[13] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h4, 1, 1, 4'h2, 2);
      vecs[14] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h2, -1);
      vecs[15] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h8, 1, 1, 4'h4, 3);
      vecs[16] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h0, 0, 1, 4'h4, -1);
      vecs[17] = mk(0, 4'hF, 4'hF, 1, 1, 1, 4'hF, 4'h1, 1, 1, 4'h4, 0);
      vecs[18] = mk(0, 4'h0, 4'h0, 1, 0, 0, 4'hF, 4'h0, 0, 1, 4'h0, -1);

      for (int i = 0; i < 19; i++) begin
         if (vecs[i].rst_first) do_reset();
         @(negedge clk);
         drive(vecs[i].rv, vecs[i].rl, vecs[i].eir,
               vecs[i].eov, vecs[i].eol, vecs[i].rr);
         #1;
         chk($sformatf("v%0d_req_ready", i), 64'(req_ready),
             64'(vecs[i].x_rr));
         chk($sformatf("v%0d_eng_in_valid", i), 64'(eng_in_valid),
             64'(vecs[i].x_eiv));
         chk($sformatf("v%0d_eng_out_ready", i), 64'(eng_out_ready),
             64'(vecs[i].x_eor));
         chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid),
             64'(vecs[i].x_rv));
         if (vecs[i].src >= 0) begin
            chk_data($sformatf("v%0d_eng_in_data", i), eng_in_data,
                     pat(vecs[i].src));
         end
      end

      // engine stalled: only TAG_DEPTH grants
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'hF);
         #1;
         if (eng_in_valid && eng_in_ready) grants.push_back(owner(req_ready));
      end
      chk("t3_grant_count", 64'(grants.size()), 64'd4);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("t3_grant_order%0d", g),
             64'(g < grants.size() ? grants[g] : -1), 64'(g));
      end
      chk("t3_blocked", 64'(req_ready), 64'd0);

      // drain: full judged pre-pop, then refill keeps order
      grants.delete();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         drive((c < 5) ? 4'hF : 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF);
         #1;
         if (c == 3) chk("t4_no_grant_while_full", 64'(req_ready), 64'd0);
         if (c == 4) chk("t4_grant_after_pop", 64'(req_ready), 64'h1);
         if (eng_in_valid && eng_in_ready) grants.push_back(owner(req_ready));
         if (eng_out_valid && eng_out_ready && eng_out_last)
            resps.push_back(owner(resp_valid));
      end
      chk("t4_refill_grants", 64'(grants.size()), 64'd1);
      chk("t4_refill_owner", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
      chk("t4_resp_count", 64'(resps.size()), 64'd15);
      for (int r = 0; r < 15; r++) begin
         exp_owner = (r < 12) ? r / 3 : 0;
         chk($sformatf("t4_resp_owner%0d", r),
             64'(r < resps.size() ? resps[r] : -1), 64'(exp_owner));
      end

      // toggled backpressure, scoreboard by owner
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(4'h6, 4'h6, 1'b1, 1'b0, 1'b0, 4'h0);
      end
      k = 0;
      for (int c = 0; c < 60 && k < 12; c++) begin
         @(negedge clk);
         exp_owner = (k < 6) ? 1 : 2;
         tog = c[0];
         oh = 4'h1 << exp_owner;
         drive(4'h0, 4'h0, 1'b1, 1'b1, k[0], tog ? oh : ~oh);
         eng_out_data = DW'(k);
         #1;
         chk($sformatf("t5_mirror_c%0d", c), 64'(eng_out_ready), 64'(tog));
         if (eng_out_valid && eng_out_ready) begin
            chk($sformatf("t5_owner_b%0d", k), 64'(resp_valid), 64'(oh));
            chk($sformatf("t5_data_b%0d", k), resp_data[63:0], 64'(k));
            k++;
         end
      end
      chk("t5_all_beats", 64'(k), 64'd12);
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF);
      #1;
      chk("t5_drained", 64'(eng_out_ready), 64'd0);
`ifdef ROT_ARB_STATS_EN
      chk("t5_stat_jobs", stat_jobs, 64'h0000_0001_0001_0000);
`endif

      // reset mid-packet
      @(negedge clk);
      drive(4'h4, 4'h4, 1'b1, 1'b0, 1'b0, 4'hF);
      @(negedge clk);
      #1;
      chk("t6_grant2", 64'(req_ready), 64'h4);
      @(negedge clk);
      drive(4'h9, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF);
      @(negedge clk);
      #1;
      chk("t6_mid_xfer", 64'(req_ready), 64'h8);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_req_ready", 64'(req_ready), 64'd0);
      chk("t6_rst_eng_in_valid", 64'(eng_in_valid), 64'd0);
      chk("t6_rst_eng_out_ready", 64'(eng_out_ready), 64'd0);
      chk("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
`ifdef ROT_ARB_STATS_EN
      chk("t6_rst_stat_jobs", stat_jobs, 64'd0);
`endif
      @(negedge clk);
      #1;
      chk("t6_rr_ptr_zero", 64'(req_ready), 64'h1);
      chk_data("t6_data", eng_in_data, pat(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
